// File: rtl/io_pkg.sv
// io_pkg: shared defaults and width helper for the I/O port controller
package io_pkg;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_NPORTS = 4;
  localparam int DEF_DEB_CYCLES = 500000;
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/io_debounce.sv
// io_debounce: 2-flop synchroniser plus stability-window debouncer for one port
module io_debounce
  import io_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEB_CYCLES = DEF_DEB_CYCLES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] i_raw,
  output logic [WIDTH-1:0] o_deb,
  output logic             o_chg
);
  localparam int CW = cnt_width(DEB_CYCLES);
  localparam logic [CW-1:0] CMAX = CW'(DEB_CYCLES - 1);
  logic [WIDTH-1:0] r_sync1, r_sync2, r_cand, r_deb;
  logic [CW-1:0] r_cnt;
  logic w_load;
  // the sample being accepted must still match, so a glitch ending on the load edge is dropped
  assign w_load = (r_cnt == CMAX) && (r_sync2 == r_cand) && (r_cand != r_deb);
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_cand <= '0;
      r_deb <= '0;
      r_cnt <= '0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
      if (r_sync2 != r_cand) begin
        r_cand <= r_sync2;
        r_cnt <= '0;
      end else if (r_cnt != CMAX) r_cnt <= r_cnt + 1'b1;
      if (w_load) r_deb <= r_cand;
    end
  end
  assign o_deb = r_deb;
  assign o_chg = w_load;
endmodule

// File: rtl/io_port_ctrl.sv
// io_port_ctrl: debounced input ports, CPU-written output ports and masked interrupt
module io_port_ctrl
  import io_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NPORTS = DEF_NPORTS,
  parameter int DEB_CYCLES = DEF_DEB_CYCLES,
  parameter int SEL_W = cnt_width(NPORTS)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NPORTS*WIDTH-1:0] raw_in,
  input  logic [SEL_W-1:0]        port_sel,
  input  logic                    we,
  input  logic [WIDTH-1:0]        wdata,
  input  logic                    mask_we,
  input  logic                    rd_ack,
  output logic [WIDTH-1:0]        rdata,
  output logic [NPORTS-1:0]       in_valid,
  output logic                    irq,
  output logic [NPORTS*WIDTH-1:0] out_data
);
  logic [WIDTH-1:0] w_deb [NPORTS];
  logic [NPORTS-1:0] w_chg, w_ack;
  logic [NPORTS-1:0] r_valid, r_mask;
  logic [NPORTS*WIDTH-1:0] r_out;
  logic r_irq;
  for (genvar k = 0; k < NPORTS; k++) begin : g_port
    io_debounce #(.WIDTH(WIDTH), .DEB_CYCLES(DEB_CYCLES)) u_deb (
      .clk  (clk),
      .reset(reset),
      .i_raw(raw_in[k*WIDTH +: WIDTH]),
      .o_deb(w_deb[k]),
      .o_chg(w_chg[k])
    );
    assign w_ack[k] = rd_ack && (port_sel == SEL_W'(k));
  end
  // out-of-range selects match no port, so they read zero and write nothing
  always_comb begin
    rdata = '0;
    for (int k = 0; k < NPORTS; k++) rdata = (port_sel == SEL_W'(k)) ? w_deb[k] : rdata;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= '0;
      r_mask <= '0;
      r_out <= '0;
      r_irq <= 1'b0;
    end else begin
      r_valid <= (r_valid & ~w_ack) | w_chg;
      r_irq <= |(r_valid & r_mask);
      if (mask_we) r_mask <= wdata[NPORTS-1:0];
      for (int k = 0; k < NPORTS; k++)
        if (we && (port_sel == SEL_W'(k))) r_out[k*WIDTH +: WIDTH] <= wdata;
    end
  end
  assign in_valid = r_valid;
  assign irq = r_irq;
  assign out_data = r_out;
endmodule

// File: tb/tb_io_port_ctrl.sv
// tb_io_port_ctrl: directed self-checking bench for io_port_ctrl
module tb_io_port_ctrl;
  logic clk = 1'b0;
  logic reset;
  logic [31:0] raw_in;
  logic [2:0] port_sel;
  logic we, mask_we, rd_ack;
  logic [7:0] wdata, rdata;
  logic [3:0] in_valid;
  logic irq;
  logic [31:0] out_data;
  int checks = 0;
  int errors = 0;
  io_port_ctrl #(.WIDTH(8), .NPORTS(4), .DEB_CYCLES(4), .SEL_W(3)) dut (
    .clk(clk), .reset(reset), .raw_in(raw_in), .port_sel(port_sel), .we(we),
    .wdata(wdata), .mask_we(mask_we), .rd_ack(rd_ack), .rdata(rdata),
    .in_valid(in_valid), .irq(irq), .out_data(out_data)
  );
  always #5 clk = ~clk;
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic test_reset;
    reset = 1'b1; raw_in = '0; port_sel = '0; we = 0; mask_we = 0; rd_ack = 0; wdata = '0;
    step(2);
    reset = 1'b0;
    #1;
    checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL rst_out got %h exp %h", out_data, 32'h0); end
    checks++; if (in_valid !== 4'h0) begin errors++; $display("FAIL rst_valid got %h exp %h", in_valid, 4'h0); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL rst_irq got %b exp 0", irq); end
    checks++; if (rdata !== 8'h00) begin errors++; $display("FAIL rst_rdata got %h exp 00", rdata); end
  endtask
  task automatic test_debounce;
    mask_we = 1; wdata = 8'h02;
    step(1);
    mask_we = 0;
    port_sel = 3'd1; raw_in[15:8] = 8'hA5;
    step(6);
    checks++; if (in_valid !== 4'h0) begin errors++; $display("FAIL deb_early_valid got %h exp %h", in_valid, 4'h0); end
    checks++; if (rdata !== 8'h00) begin errors++; $display("FAIL deb_early_rdata got %h exp 00", rdata); end
    step(1);
    checks++; if (rdata !== 8'hA5) begin errors++; $display("FAIL deb_rdata got %h exp a5", rdata); end
    checks++; if (in_valid !== 4'h2) begin errors++; $display("FAIL deb_valid got %h exp %h", in_valid, 4'h2); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL deb_irq_early got %b exp 0", irq); end
    step(1);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL deb_irq got %b exp 1", irq); end
  endtask
  task automatic test_glitch;
    raw_in[7:0] = 8'h01;
    step(3);
    raw_in[7:0] = 8'h00;
    step(10);
    port_sel = 3'd0;
    #1;
    checks++; if (rdata !== 8'h00) begin errors++; $display("FAIL glitch_rdata got %h exp 00", rdata); end
    checks++; if (in_valid !== 4'h2) begin errors++; $display("FAIL glitch_valid got %h exp %h", in_valid, 4'h2); end
  endtask
  task automatic test_write;
    we = 1; port_sel = 3'd2; wdata = 8'h3C;
    step(1);
    we = 0;
    checks++; if (out_data !== 32'h003C0000) begin errors++; $display("FAIL wr_port2 got %h exp %h", out_data, 32'h003C0000); end
    we = 1; mask_we = 1; port_sel = 3'd0; wdata = 8'h0A;
    step(1);
    we = 0; mask_we = 0;
    checks++; if (out_data !== 32'h003C000A) begin errors++; $display("FAIL wr_port0 got %h exp %h", out_data, 32'h003C000A); end
  endtask
  task automatic test_ack_collision;
    port_sel = 3'd1; rd_ack = 1;
    step(1);
    rd_ack = 0;
    checks++; if (in_valid !== 4'h0) begin errors++; $display("FAIL ack1_valid got %h exp %h", in_valid, 4'h0); end
    raw_in[31:24] = 8'h77;
    step(6);
    rd_ack = 1; port_sel = 3'd3;
    step(1);
    checks++; if (in_valid !== 4'h8) begin errors++; $display("FAIL coll_valid got %h exp %h", in_valid, 4'h8); end
    step(1);
    rd_ack = 0;
    checks++; if (in_valid !== 4'h0) begin errors++; $display("FAIL ack3_valid got %h exp %h", in_valid, 4'h0); end
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL coll_irq got %b exp 1", irq); end
    step(1);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_drop got %b exp 0", irq); end
  endtask
  task automatic test_bad_sel;
    port_sel = 3'd5; we = 1; wdata = 8'hFF;
    step(1);
    we = 0;
    checks++; if (out_data !== 32'h003C000A) begin errors++; $display("FAIL badsel_out got %h exp %h", out_data, 32'h003C000A); end
    checks++; if (rdata !== 8'h00) begin errors++; $display("FAIL badsel_rdata got %h exp 00", rdata); end
  endtask
  task automatic test_reset_mid;
    raw_in[15:8] = 8'h00;
    step(10);
    raw_in[15:8] = 8'hA5;
    step(4);
    reset = 1;
    step(1);
    reset = 0; port_sel = 3'd1;
    #1;
    checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL mid_out got %h exp %h", out_data, 32'h0); end
    checks++; if (in_valid !== 4'h0) begin errors++; $display("FAIL mid_valid got %h exp %h", in_valid, 4'h0); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL mid_irq got %b exp 0", irq); end
    checks++; if (rdata !== 8'h00) begin errors++; $display("FAIL mid_rdata got %h exp 00", rdata); end
    step(6);
    checks++; if (in_valid !== 4'h0) begin errors++; $display("FAIL redeb_early got %h exp %h", in_valid, 4'h0); end
    step(1);
    checks++; if (in_valid !== 4'hA) begin errors++; $display("FAIL redeb_valid got %h exp %h", in_valid, 4'hA); end
    checks++; if (rdata !== 8'hA5) begin errors++; $display("FAIL redeb_rdata got %h exp a5", rdata); end
  endtask
  initial begin
    test_reset;
    test_debounce;
    test_glitch;
    test_write;
    test_ack_collision;
    test_bad_sel;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/io_port_ctrl.md
IO_PORT_CTRL -- requirements
Module: io_port_ctrl

Interface
REQ-001 Parameter WIDTH, default 8: bit width of every I/O port.
REQ-002 Parameter NPORTS, default 4: number of input ports and number of output ports, range 1..16.
REQ-003 Parameter DEB_CYCLES, default 500000: debounce stability window in clock cycles, minimum 1.
REQ-004 Port clk  input  1: single system clock; all state updates on its rising edge.
REQ-005 Port reset  input  1: synchronous, active-high reset.
REQ-006 Port raw_in  input  NPORTS*WIDTH: asynchronous external inputs (buttons, switches); port k occupies bits [k*WIDTH +: WIDTH].
REQ-007 Port port_sel  input  clog2(NPORTS), minimum 1: CPU port index for write, read and acknowledge.
REQ-008 Port we  input  1: CPU write strobe to output port port_sel.
REQ-009 Port wdata  input  WIDTH: CPU write data.
REQ-010 Port mask_we  input  1: write strobe to the interrupt-mask register; mask is loaded from wdata[NPORTS-1:0].
REQ-011 Port rd_ack  input  1: CPU has consumed port port_sel; clears its valid flag.
REQ-012 Port rdata  output  WIDTH: debounced value of input port port_sel, combinational.
REQ-013 Port in_valid  output  NPORTS: per-port new-data flag.
REQ-014 Port irq  output  1: registered interrupt request.
REQ-015 Port out_data  output  NPORTS*WIDTH: registered output ports.

Function
REQ-016 Each raw_in bit SHALL pass through a 2-flop synchroniser before any other logic.
REQ-017 Per-port debounce: a candidate register takes the synchronised word; any mismatch reloads the candidate and clears the counter; otherwise the counter increments and saturates at DEB_CYCLES-1.
REQ-018 The debounced value SHALL load the candidate on the edge after the counter equals DEB_CYCLES-1 and the candidate differs from the debounced value.
REQ-019 Latency: raw change held stable -> debounced value and in_valid[k] update on clock edge DEB_CYCLES+3 after the change is sampled; glitches shorter than DEB_CYCLES+1 cycles SHALL NOT propagate.
REQ-020 in_valid[k] SHALL set on every debounced-value change of port k and clear on rd_ack with port_sel==k.
REQ-021 Set and rd_ack on the same port in the same cycle: set wins (in_valid stays 1).
REQ-022 we: out_data port port_sel <= wdata on the next edge; other ports hold.
REQ-023 port_sel >= NPORTS: we, rd_ack ignored; rdata = 0.
REQ-024 we and mask_we in the same cycle: both take effect.
REQ-025 irq SHALL be registered as OR over k of (in_valid[k] AND mask[k]), one cycle after the contributing flags.

Reset
REQ-026 On reset: out_data=0, in_valid=0, mask=0, irq=0, all synchroniser, candidate, debounced and counter registers=0.
REQ-027 Reset asserted mid-debounce SHALL discard the pending change; an input still non-zero after reset is re-debounced with full latency and raises in_valid.

Structure
REQ-028 Defaults for WIDTH, NPORTS, DEB_CYCLES and the counter-width function SHALL live in shared package io_pkg.
REQ-029 One sub-module io_debounce (sync + candidate + counter + debounced register, WIDTH bits) SHALL be instantiated NPORTS times.
REQ-030 Target size 150-300 RTL lines; no latches, no multi-clock logic.

Verification (bench uses DEB_CYCLES=4, WIDTH=8, NPORTS=4)
REQ-031 raw port 1 0x00->0xA5 held -> rdata(sel=1)=0xA5 and in_valid[1]=1 exactly 7 edges later; mask=0x2 -> irq=1 one cycle after.
REQ-032 raw port 0 pulses 0x01 for 3 cycles -> in_valid stays 0, rdata(sel=0)=0x00.
REQ-033 we=1, sel=2, wdata=0x3C -> out_data port 2 = 0x3C next edge; ports 0,1,3 unchanged.
REQ-034 in_valid[3] set and rd_ack sel=3 same cycle -> in_valid[3]=1; next rd_ack alone -> 0, irq drops one cycle later.
REQ-035 reset during count (edge 5 of 7) -> all outputs 0; raw still 0xA5 -> in_valid set 7 edges after reset release.
REQ-036 sel=5 with NPORTS=4 (3-bit sel build): we=1 -> no out_data change, rdata=0.
